// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back / memory-access stage:
// FSM states, result-select and access-size encodings, byte-lane helpers.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_ALU   = 3'd0,
        SEL_SHIFT = 3'd1,
        SEL_LOGIC = 3'd2,
        SEL_LOAD  = 3'd3,
        SEL_SLT   = 3'd4,
        SEL_SLTU  = 3'd5,
        SEL_UIMM  = 3'd6,
        SEL_ZERO  = 3'd7
    } sel_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Raw size field: 2 and 3 both mean a full word.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    decode_size = SZ_B;
            2'd1:    decode_size = SZ_H;
            default: decode_size = SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    byte_en = 4'b0001 << off;
            SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input size_e sz, input logic [31:0] d);
        case (sz)
            SZ_B:    replicate = {4{d[7:0]}};
            SZ_H:    replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_H:    misaligned = off[0];
            SZ_W:    misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_ld_align.sv
// Load lane extraction: picks the byte/half lane out of the read word and
// sign- or zero-extends it to 32 bits.
module ld_align
    import wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lane_b = rdata[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (size)
            SZ_B:    data = {{24{sgn & lane_b[7]}}, lane_b};
            SZ_H:    data = {{16{sgn & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU-class results in one cycle, runs loads/stores
// over a req/gnt/rvalid data-memory port. Optional feature: MISALIGN_TRAP_EN.
module wb_stage
    import wb_pkg::*;
(
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  RegMuxS,
    input  logic [31:0] ALURes,
    input  logic [31:0] ShiftRes,
    input  logic [31:0] LogicRes,
    input  logic [31:0] StoreData,
    input  logic [19:0] uimm,
    input  logic        SLT,
    input  logic        SLTU,
    input  logic [4:0]  rd,
    input  logic        RWE,
    input  logic        MWE,
    input  logic [1:0]  WWHBS,
    input  logic [1:0]  RWHBS,
    input  logic        LS,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        trap
);

    state_e      state_q, state_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;

    // Load context held across the memory handshake.
    logic [4:0]  rd_q, rd_d;
    logic        ls_q, ls_d;
    size_e       size_q, size_d;
    logic [1:0]  off_q, off_d;

    logic        accept;
    logic        is_load;
    logic        is_store;
    logic        misalign;
    size_e       acc_size;
    logic [31:0] alu_result;
    logic [31:0] ld_data;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign is_load  = (RegMuxS == SEL_LOAD) && RWE;
    assign is_store = MWE && !is_load;
    assign acc_size = decode_size(is_load ? RWHBS : WWHBS);

`ifdef MISALIGN_TRAP_EN
    assign misalign = misaligned(acc_size, ALURes[1:0]);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        alu_result = 32'h0;
        case (RegMuxS)
            SEL_ALU:   alu_result = ALURes;
            SEL_SHIFT: alu_result = ShiftRes;
            SEL_LOGIC: alu_result = LogicRes;
            SEL_SLT:   alu_result = {31'b0, SLT};
            SEL_SLTU:  alu_result = {31'b0, SLTU};
            SEL_UIMM:  alu_result = {uimm, 12'b0};
            default:   alu_result = 32'h0;
        endcase
    end

    ld_align u_ld_align (
        .rdata (dm_rdata),
        .addr  (off_q),
        .size  (size_q),
        .sgn   (ls_q),
        .data  (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        rd_d       = rd_q;
        ls_d       = ls_q;
        size_d     = size_q;
        off_d      = off_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_load || is_store) begin
                        if (!misalign) begin
                            state_d    = ST_REQ;
                            dm_req_d   = 1'b1;
                            dm_we_d    = is_store;
                            dm_addr_d  = {ALURes[31:2], 2'b00};
                            dm_be_d    = byte_en(acc_size, ALURes[1:0]);
                            dm_wdata_d = is_store ? replicate(acc_size, StoreData) : dm_wdata_q;
                            rd_d       = rd;
                            ls_d       = LS;
                            size_d     = acc_size;
                            off_d      = ALURes[1:0];
                        end
                    end else begin
                        rf_we_d    = RWE && (rd != 5'd0);
                        rf_waddr_d = rd;
                        rf_wdata_d = alu_result;
                    end
                end
            end
            ST_REQ: begin
                if (dm_gnt) begin
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    state_d  = dm_we_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dm_rvalid) begin
                    rf_we_d    = (rd_q != 5'd0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = ld_data;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'h0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'h0;
            dm_be_q    <= 4'h0;
            dm_wdata_q <= 32'h0;
            rd_q       <= 5'd0;
            ls_q       <= 1'b0;
            size_q     <= SZ_B;
            off_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            rd_q       <= rd_d;
            ls_q       <= ls_d;
            size_q     <= size_d;
            off_q      <= off_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= accept && (is_load || is_store) && misalign;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_be    = dm_be_q;
    assign dm_wdata = dm_wdata_q;

endmodule
